// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID instruction in, registered EX instruction plus stall/counters out.
// master = ID side / environment, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4
);
    logic           id_valid;
    logic [DW-1:0]  id_pc;
    logic [AW-1:0]  id_rs;
    logic [AW-1:0]  id_rt;
    logic [AW-1:0]  id_rd;
    logic           id_usesRt;
    logic [DW-1:0]  id_data1;
    logic [DW-1:0]  id_data2;
    logic [DW-1:0]  id_imm;
    logic           id_regWrite;
    logic           id_memRead;
    logic           id_memWrite;
    logic           id_aluSrc;
    logic           id_regDst;
    logic [OPW-1:0] id_aluOp;
    logic           flush;
    logic           ex_hold;

    logic           stall;
    logic           ex_valid;
    logic [DW-1:0]  ex_pc;
    logic [DW-1:0]  ex_data1;
    logic [DW-1:0]  ex_data2;
    logic [DW-1:0]  ex_imm;
    logic [AW-1:0]  ex_rs;
    logic [AW-1:0]  ex_rt;
    logic [AW-1:0]  ex_wreg;
    logic           ex_regWrite;
    logic           ex_memRead;
    logic           ex_memWrite;
    logic           ex_aluSrc;
    logic [OPW-1:0] ex_aluOp;
    logic [15:0]    stall_cnt;
    logic [15:0]    flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_usesRt, id_data1, id_data2, id_imm,
               id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_regDst, id_aluOp,
               flush, ex_hold,
        input  stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_wreg,
               ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_usesRt, id_data1, id_data2, id_imm,
               id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_regDst, id_aluOp,
               flush, ex_hold,
        output stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_wreg,
               ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble, flush and downstream hold; 1-cycle latency.
// Stall is combinational back to IF/ID; HAZARD_CNT_EN adds saturating bubble/flush counters.
module id_ex_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic           valid;
        logic [DW-1:0]  pc;
        logic [DW-1:0]  data1;
        logic [DW-1:0]  data2;
        logic [DW-1:0]  imm;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [AW-1:0]  wreg;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic           alu_src;
        logic [OPW-1:0] alu_op;
    } ex_t;

    ex_t           ex_q;
    ex_t           ex_d;
    ex_t           load_d;
    logic [AW-1:0] id_wreg;
    logic          hazard;
    logic          bubble;

    assign id_wreg = bus.id_regDst ? bus.id_rd : bus.id_rt;

    // Only a load that will really write a nonzero register can cause a load-use hazard.
    assign hazard = ex_q.valid & ex_q.mem_read & ex_q.reg_write & bus.id_valid
                  & (ex_q.wreg != '0)
                  & ((ex_q.wreg == bus.id_rs) | (bus.id_usesRt & (ex_q.wreg == bus.id_rt)));

    assign bus.stall = (hazard | bus.ex_hold) & ~bus.flush;
    assign bubble    = ~bus.flush & ~bus.ex_hold & hazard;

    always_comb begin
        load_d           = '0;
        load_d.valid     = bus.id_valid;
        load_d.pc        = bus.id_pc;
        load_d.data1     = bus.id_data1;
        load_d.data2     = bus.id_data2;
        load_d.imm       = bus.id_imm;
        load_d.rs        = bus.id_rs;
        load_d.rt        = bus.id_rt;
        load_d.wreg      = id_wreg;
        load_d.reg_write = bus.id_valid & bus.id_regWrite & (id_wreg != '0);
        load_d.mem_read  = bus.id_valid & bus.id_memRead;
        load_d.mem_write = bus.id_valid & bus.id_memWrite;
        load_d.alu_src   = bus.id_valid & bus.id_aluSrc;
        load_d.alu_op    = bus.id_valid ? bus.id_aluOp : '0;
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.ex_hold) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d = load_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_data1    = ex_q.data1;
    assign bus.ex_data2    = ex_q.data2;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_wreg     = ex_q.wreg;
    assign bus.ex_regWrite = ex_q.reg_write;
    assign bus.ex_memRead  = ex_q.mem_read;
    assign bus.ex_memWrite = ex_q.mem_write;
    assign bus.ex_aluSrc   = ex_q.alu_src;
    assign bus.ex_aluOp    = ex_q.alu_op;

`ifdef HAZARD_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (bus.flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a slot-level reference model.
module tb_id_ex_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   cmp_en;

    id_ex_stage_if #(.DW(32), .AW(5), .OPW(4)) bus ();

    id_ex_stage #(.DW(32), .AW(5), .OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what instruction (if any) sits in EX, plus event tallies.
    typedef struct {
        bit          valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs, rt, wreg;
        bit          rw, mr, mw, as;
        logic [3:0]  op;
    } slot_t;

    slot_t m_slot;
    int    m_bubbles;
    int    m_flushes;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic slot_t id_slot();
        slot_t s;
        s.valid = bus.id_valid;
        s.pc    = bus.id_pc;
        s.d1    = bus.id_data1;
        s.d2    = bus.id_data2;
        s.imm   = bus.id_imm;
        s.rs    = bus.id_rs;
        s.rt    = bus.id_rt;
        s.wreg  = bus.id_regDst ? bus.id_rd : bus.id_rt;
        s.rw    = bus.id_valid && bus.id_regWrite && (s.wreg != 0);
        s.mr    = bus.id_valid && bus.id_memRead;
        s.mw    = bus.id_valid && bus.id_memWrite;
        s.as    = bus.id_valid && bus.id_aluSrc;
        s.op    = bus.id_valid ? bus.id_aluOp : 4'd0;
        return s;
    endfunction

    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (m_slot.wreg == bus.id_rs) || (bus.id_usesRt && (m_slot.wreg == bus.id_rt));
        return m_slot.valid && m_slot.mr && m_slot.rw && bus.id_valid
               && (m_slot.wreg != 0) && reads_it;
    endfunction

    function automatic bit model_stall();
        return (model_hazard() || bus.ex_hold) && !bus.flush;
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef HAZARD_CNT_EN
        return (n > 65535) ? 16'hFFFF : n[15:0];
`else
        return (n >= 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    initial begin
        m_slot    = empty_slot();
        m_bubbles = 0;
        m_flushes = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_slot    = empty_slot();
            m_bubbles = 0;
            m_flushes = 0;
        end else if (bus.flush) begin
            m_slot    = empty_slot();
            m_flushes = m_flushes + 1;
        end else if (bus.ex_hold) begin
            m_slot = m_slot;
        end else if (model_hazard()) begin
            m_slot    = empty_slot();
            m_bubbles = m_bubbles + 1;
        end else begin
            m_slot = id_slot();
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m.stall",     64'(bus.stall),       64'(model_stall()));
            check("m.valid",     64'(bus.ex_valid),    64'(m_slot.valid));
            check("m.pc",        64'(bus.ex_pc),       64'(m_slot.pc));
            check("m.data1",     64'(bus.ex_data1),    64'(m_slot.d1));
            check("m.data2",     64'(bus.ex_data2),    64'(m_slot.d2));
            check("m.imm",       64'(bus.ex_imm),      64'(m_slot.imm));
            check("m.rs",        64'(bus.ex_rs),       64'(m_slot.rs));
            check("m.rt",        64'(bus.ex_rt),       64'(m_slot.rt));
            check("m.wreg",      64'(bus.ex_wreg),     64'(m_slot.wreg));
            check("m.regWrite",  64'(bus.ex_regWrite), 64'(m_slot.rw));
            check("m.memRead",   64'(bus.ex_memRead),  64'(m_slot.mr));
            check("m.memWrite",  64'(bus.ex_memWrite), 64'(m_slot.mw));
            check("m.aluSrc",    64'(bus.ex_aluSrc),   64'(m_slot.as));
            check("m.aluOp",     64'(bus.ex_aluOp),    64'(m_slot.op));
            check("m.stall_cnt", 64'(bus.stall_cnt),   64'(exp_cnt(m_bubbles)));
            check("m.flush_cnt", 64'(bus.flush_cnt),   64'(exp_cnt(m_flushes)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid    = 1'b0;
        bus.id_pc       = '0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_rd       = '0;
        bus.id_usesRt   = 1'b0;
        bus.id_data1    = '0;
        bus.id_data2    = '0;
        bus.id_imm      = '0;
        bus.id_regWrite = 1'b0;
        bus.id_memRead  = 1'b0;
        bus.id_memWrite = 1'b0;
        bus.id_aluSrc   = 1'b0;
        bus.id_regDst   = 1'b0;
        bus.id_aluOp    = '0;
        bus.flush       = 1'b0;
        bus.ex_hold     = 1'b0;
    endtask

    // Drive an lw rt <- mem[rs+imm] into ID.
    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_pc       = 32'h40;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_imm      = 32'h4;
        bus.id_regWrite = 1'b1;
        bus.id_memRead  = 1'b1;
        bus.id_aluSrc   = 1'b1;
    endtask

    logic [15:0] cnt0;

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst    = 1'b0;
        clear_id();

        // Reset held two cycles.
        tick();
        tick();
        check("rst.ex_valid", 64'(bus.ex_valid), 64'd0);
        check("rst.ex_pc",    64'(bus.ex_pc),    64'd0);
        check("rst.ex_wreg",  64'(bus.ex_wreg),  64'd0);
        check("rst.stall",    64'(bus.stall),    64'd0);
        check("rst.cnts",     64'({bus.stall_cnt, bus.flush_cnt}), 64'd0);
        cmp_en = 1'b1;
        rst    = 1'b1;

        // R-type with regDst picks rd.
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_pc       = 32'h100;
        bus.id_regDst   = 1'b1;
        bus.id_regWrite = 1'b1;
        bus.id_rt       = 5'd5;
        bus.id_rd       = 5'd9;
        bus.id_data1    = 32'd7;
        bus.id_data2    = 32'd1;
        tick();
        check("rtype.wreg",  64'(bus.ex_wreg),     64'd9);
        check("rtype.data1", 64'(bus.ex_data1),    64'd7);
        check("rtype.data2", 64'(bus.ex_data2),    64'd1);
        check("rtype.valid", 64'(bus.ex_valid),    64'd1);
        check("rtype.rw",    64'(bus.ex_regWrite), 64'd1);

        // Load-use on r3: one stall cycle, one bubble, then the add.
        drive_lw(5'd1, 5'd3);
        tick();
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_rs       = 5'd3;
        bus.id_rt       = 5'd4;
        bus.id_rd       = 5'd6;
        bus.id_usesRt   = 1'b1;
        bus.id_regDst   = 1'b1;
        bus.id_regWrite = 1'b1;
        #1;
        check("lu.stall", 64'(bus.stall), 64'd1);
        cnt0 = bus.stall_cnt;
        tick();
        check("lu.bubble",       64'(bus.ex_valid), 64'd0);
        check("lu.stall_after",  64'(bus.stall),    64'd0);
`ifdef HAZARD_CNT_EN
        check("lu.stall_cnt", 64'(bus.stall_cnt), 64'(cnt0 + 16'd1));
`else
        check("lu.stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif
        tick();
        check("lu.add_valid", 64'(bus.ex_valid), 64'd1);
        check("lu.add_wreg",  64'(bus.ex_wreg),  64'd6);

        // Load into r0 never hazards; rd=0 write is suppressed.
        drive_lw(5'd2, 5'd0);
        tick();
        check("r0.lw_rw", 64'(bus.ex_regWrite), 64'd0);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_rs       = 5'd0;
        bus.id_rd       = 5'd0;
        bus.id_regDst   = 1'b1;
        bus.id_regWrite = 1'b1;
        #1;
        check("r0.stall", 64'(bus.stall), 64'd0);
        tick();
        check("r0.valid", 64'(bus.ex_valid),    64'd1);
        check("r0.rw",    64'(bus.ex_regWrite), 64'd0);

        // Flush beats hold and hazard.
        drive_lw(5'd1, 5'd3);
        tick();
        clear_id();
        bus.id_valid = 1'b1;
        bus.id_rs    = 5'd3;
        bus.flush    = 1'b1;
        bus.ex_hold  = 1'b1;
        #1;
        check("fl.stall", 64'(bus.stall), 64'd0);
        cnt0 = bus.flush_cnt;
        tick();
        check("fl.valid", 64'(bus.ex_valid), 64'd0);
`ifdef HAZARD_CNT_EN
        check("fl.flush_cnt", 64'(bus.flush_cnt), 64'(cnt0 + 16'd1));
`else
        check("fl.flush_cnt", 64'(bus.flush_cnt), 64'd0);
`endif

        // Downstream hold freezes EX for three cycles.
        clear_id();
        bus.id_valid = 1'b1;
        bus.id_pc    = 32'h200;
        bus.id_rs    = 5'd7;
        tick();
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.id_pc = 32'h300 + 32'(i);
            #1;
            check("hold.stall", 64'(bus.stall), 64'd1);
            tick();
            check("hold.pc",    64'(bus.ex_pc),    64'h200);
            check("hold.valid", 64'(bus.ex_valid), 64'd1);
        end
        bus.ex_hold = 1'b0;

        // Random traffic; small register range makes hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 49) != 0);
            bus.id_valid    = ($urandom_range(0, 4) != 0);
            bus.id_pc       = $urandom;
            bus.id_rs       = 5'($urandom_range(0, 3));
            bus.id_rt       = 5'($urandom_range(0, 3));
            bus.id_rd       = 5'($urandom_range(0, 3));
            bus.id_usesRt   = 1'($urandom);
            bus.id_data1    = $urandom;
            bus.id_data2    = $urandom;
            bus.id_imm      = $urandom;
            bus.id_regWrite = ($urandom_range(0, 3) != 0);
            bus.id_memRead  = 1'($urandom);
            bus.id_memWrite = 1'($urandom);
            bus.id_aluSrc   = 1'($urandom);
            bus.id_regDst   = 1'($urandom);
            bus.id_aluOp    = 4'($urandom);
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.ex_hold     = ($urandom_range(0, 6) == 0);
            tick();
        end

`ifdef HAZARD_CNT_EN
        // Drive the flush counter past its ceiling.
        rst = 1'b1;
        clear_id();
        bus.flush = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("sat.flush_cnt", 64'(bus.flush_cnt), 64'hFFFF);
        bus.flush = 1'b0;
`endif

        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
